sequenciador_multiciclo: RTL

Multi-cycle sequencer for the 8-bit accumulator CPU datapath.

- Replaces single-cycle enabling: splits each instruction into FETCH/DECODE/EXEC/MEM/WB phases.
- Gates the `Controle` outputs into per-phase write enables for IR, register bank, RAM and PC.
- Adds run/single-step control, a RAM wait-state handshake with timeout, and a retired-instruction counter for debug.

---
 rtl/sequenciador_multiciclo_if.sv | 33 +++
 rtl/sequenciador_multiciclo.sv | 106 ++++++++++
 2 files changed

// File: rtl/sequenciador_multiciclo_if.sv
// rtl/sequenciador_multiciclo_if.sv - control/enable bundle between the sequencer and the datapath
// master: the sequencer; slave: the datapath/Controle side that feeds it.
interface sequenciador_multiciclo_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step;
  logic             mem_read_in;
  logic             mem_write_in;
  logic             reg_write_in;
  logic             branch_taken_in;
  logic             mem_ready;
  logic             ir_we;
  logic             reg_we;
  logic             ram_re;
  logic             ram_we;
  logic             pc_we;
  logic             pc_sel;
  logic             busy;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, step, mem_read_in, mem_write_in, reg_write_in, branch_taken_in, mem_ready,
    output ir_we, reg_we, ram_re, ram_we, pc_we, pc_sel, busy, fault, state, instr_count
  );

  modport slave (
    output run, step, mem_read_in, mem_write_in, reg_write_in, branch_taken_in, mem_ready,
    input  ir_we, reg_we, ram_re, ram_we, pc_we, pc_sel, busy, fault, state, instr_count
  );
endinterface

// File: rtl/sequenciador_multiciclo.sv
// rtl/sequenciador_multiciclo.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the accumulator CPU
// Define SEQ_MEM_TIMEOUT_EN to enable the MEM wait-state timeout and the sticky FAULT state.
module sequenciador_multiciclo #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic reset,
  sequenciador_multiciclo_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             fault_q;

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  logic [WW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
`ifdef SEQ_MEM_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.run || bus.step) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          if (bus.mem_read_in || bus.mem_write_in) begin
            state_q <= S_MEM;
`ifdef SEQ_MEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            state_q <= S_WB;
`ifdef SEQ_MEM_TIMEOUT_EN
          end else if (wait_cnt == WW'(WAIT_MAX)) begin
            state_q <= S_FAULT;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        S_WB: begin
          cnt_q <= cnt_q + 1'b1;
          // Back-to-back issue while running: no IDLE bubble between instructions.
          if (bus.run) begin
            state_q <= S_FETCH;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_FAULT: state_q <= S_FAULT;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Enables are gated by reset so a pending RAM write is dropped in the reset cycle.
  always_comb begin
    bus.ir_we  = reset && (state_q == S_FETCH);
    bus.ram_re = reset && (state_q == S_MEM) && bus.mem_read_in;
    bus.ram_we = reset && (state_q == S_MEM) && bus.mem_write_in && bus.mem_ready;
    bus.reg_we = reset && (state_q == S_WB) && bus.reg_write_in;
    bus.pc_we  = reset && (state_q == S_WB);
    bus.pc_sel = reset && (state_q == S_WB) && bus.branch_taken_in;
  end

  assign bus.state       = state_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;
  assign bus.instr_count = cnt_q;
endmodule
